// File: rtl/target_round_controller.sv
// Round sequencer for the billiard target mini-game: owns the target pocket, shots and score,
// and feeds buffered pocket events to the correct-target checker one at a time.
module target_round_controller #(
   parameter int          SHOTS         = 10,
   parameter int          POINTS        = 1,
   parameter int          SETTLE_CYCLES = 4,
   parameter logic [10:0] TABLE_LEFT    = 11'd40,
   parameter logic [10:0] TABLE_RIGHT   = 11'd600,
   parameter logic [10:0] TABLE_TOP     = 11'd64,
   parameter logic [10:0] TABLE_BOTTOM  = 11'd416
) (
   input  logic        clk,
   input  logic        resetN,
   input  logic        startGame,
   input  logic        shotFired,
   input  logic        ballsMoving,
   input  logic        col1Hole,
   input  logic        col2Hole,
   input  logic        col3Hole,
   input  logic        col4Hole,
   input  logic        correctTarget,
   output logic        increasePoint,
   output logic [3:0]  holeSel,
   output logic [10:0] targetX,
   output logic [10:0] targetY,
   output logic [7:0]  score,
   output logic [3:0]  shotsLeft,
   output logic        gameOver
);

   typedef enum logic [2:0] {
      IDLE, AIM, ROLLING, ISSUE, CHECK, END_SHOT, GAME_OVER
   } state_t;

   localparam logic [11:0] MID_SUM    = {1'b0, TABLE_LEFT} + {1'b0, TABLE_RIGHT};
   localparam logic [10:0] TABLE_MID  = MID_SUM[11:1];
   localparam logic [7:0]  SETTLE_MAX = 8'(SETTLE_CYCLES);
   localparam logic [3:0]  SHOTS_INIT = 4'(SHOTS);
   localparam logic [8:0]  POINTS_W   = 9'(POINTS);

   function automatic logic [10:0] pocketX(input logic [2:0] idx);
      case (idx)
         3'd0, 3'd3: pocketX = TABLE_LEFT;
         3'd1, 3'd4: pocketX = TABLE_MID;
         default:    pocketX = TABLE_RIGHT;
      endcase
   endfunction

   function automatic logic [10:0] pocketY(input logic [2:0] idx);
      pocketY = (idx < 3'd3) ? TABLE_TOP : TABLE_BOTTOM;
   endfunction

   state_t      state;
   logic [3:0]  pending;
   logic [2:0]  rrCnt;
   logic [2:0]  tgtIdx;
   logic        hitFlag;
   logic [7:0]  settleCnt;

   logic [3:0]  holes;
   logic [3:0]  pendMerged;
   logic [3:0]  lowBit;
   logic [8:0]  scoreSum;
   logic [2:0]  nextIdx;

   assign holes      = {col4Hole, col3Hole, col2Hole, col1Hole};
   assign pendMerged = pending | holes;
   // Isolate the lowest set bit so col1 always wins when several pockets are waiting.
   assign lowBit     = pendMerged & (~pendMerged + 4'd1);
   assign scoreSum   = {1'b0, score} + POINTS_W;
   assign nextIdx    = (rrCnt == tgtIdx) ? ((tgtIdx == 3'd5) ? 3'd0 : tgtIdx + 3'd1) : rrCnt;

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state         <= IDLE;
         pending       <= 4'd0;
         rrCnt         <= 3'd0;
         tgtIdx        <= 3'd0;
         hitFlag       <= 1'b0;
         settleCnt     <= 8'd0;
         increasePoint <= 1'b0;
         holeSel       <= 4'd0;
         targetX       <= TABLE_LEFT;
         targetY       <= TABLE_TOP;
         score         <= 8'd0;
         shotsLeft     <= SHOTS_INIT;
         gameOver      <= 1'b0;
      end else begin
         rrCnt         <= (rrCnt == 3'd5) ? 3'd0 : rrCnt + 3'd1;
         increasePoint <= 1'b0;
         holeSel       <= 4'd0;

         if (state == ROLLING && !ballsMoving && pendMerged == 4'd0)
            settleCnt <= (settleCnt == SETTLE_MAX) ? settleCnt : settleCnt + 8'd1;
         else
            settleCnt <= 8'd0;

         case (state)
            IDLE, GAME_OVER: begin
               if (startGame) begin
                  score     <= 8'd0;
                  shotsLeft <= SHOTS_INIT;
                  tgtIdx    <= 3'd0;
                  targetX   <= TABLE_LEFT;
                  targetY   <= TABLE_TOP;
                  hitFlag   <= 1'b0;
                  pending   <= 4'd0;
                  gameOver  <= 1'b0;
                  state     <= AIM;
               end
            end
            AIM: begin
               if (shotFired) begin
                  shotsLeft <= shotsLeft - 4'd1;
                  state     <= ROLLING;
               end
            end
            // Events seen this cycle go straight to ISSUE so the checker request appears next cycle.
            ROLLING: begin
               pending <= pendMerged;
               if (pendMerged != 4'd0) begin
                  increasePoint <= 1'b1;
                  holeSel       <= lowBit;
                  state         <= ISSUE;
               end else if (settleCnt == SETTLE_MAX) begin
                  state <= END_SHOT;
               end
            end
            ISSUE: begin
               pending <= (pending & ~holeSel) | holes;
               state   <= CHECK;
            end
            CHECK: begin
               pending <= pendMerged;
               if (correctTarget) begin
                  score   <= (scoreSum > 9'd255) ? 8'd255 : scoreSum[7:0];
                  hitFlag <= 1'b1;
               end
               state <= ROLLING;
            end
            END_SHOT: begin
               if (hitFlag) begin
                  tgtIdx  <= nextIdx;
                  targetX <= pocketX(nextIdx);
                  targetY <= pocketY(nextIdx);
                  hitFlag <= 1'b0;
               end
               if (shotsLeft == 4'd0) begin
                  gameOver <= 1'b1;
                  state    <= GAME_OVER;
               end else begin
                  state <= AIM;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_target_round_controller.sv
// Directed self-checking bench for target_round_controller with hand-derived cycle timing.
module tb_target_round_controller;

   logic        clk;
   logic        resetN;
   logic        startGame, shotFired, ballsMoving;
   logic        col1Hole, col2Hole, col3Hole, col4Hole;
   logic        correctTarget;
   logic        increasePoint;
   logic [3:0]  holeSel;
   logic [10:0] targetX, targetY;
   logic [7:0]  score;
   logic [3:0]  shotsLeft;
   logic        gameOver;

   int checkCount = 0;
   int errorCount = 0;
   int cyc;
   int ipSeen = 0;
   int rr, t1, t2;
   int expX[6] = '{40, 320, 600, 40, 320, 600};
   int expY[6] = '{64, 64, 64, 416, 416, 416};

   localparam logic [5:0] P_START = 6'b100000;
   localparam logic [5:0] P_SHOT  = 6'b010000;
   localparam logic [5:0] P_COL1  = 6'b000001;
   localparam logic [5:0] P_COL2  = 6'b000010;
   localparam logic [5:0] P_COL3  = 6'b000100;
   localparam logic [5:0] P_COL4  = 6'b001000;

   target_round_controller dut (
      .clk(clk), .resetN(resetN), .startGame(startGame), .shotFired(shotFired),
      .ballsMoving(ballsMoving), .col1Hole(col1Hole), .col2Hole(col2Hole),
      .col3Hole(col3Hole), .col4Hole(col4Hole), .correctTarget(correctTarget),
      .increasePoint(increasePoint), .holeSel(holeSel), .targetX(targetX),
      .targetY(targetY), .score(score), .shotsLeft(shotsLeft), .gameOver(gameOver)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycles since reset release; equals the free-running pocket counter value in each cycle.
   always @(posedge clk or negedge resetN) begin
      if (!resetN) cyc <= 0;
      else         cyc <= cyc + 1;
   end

   always @(negedge clk) if (increasePoint) ipSeen++;

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [5:0] pulses);
      {startGame, shotFired, col4Hole, col3Hole, col2Hole, col1Hole} = pulses;
      step(1);
      {startGame, shotFired, col4Hole, col3Hole, col2Hole, col1Hole} = 6'b0;
   endtask

   task automatic checkOutput(input string tag, input int observed, input int expected);
      checkCount++;
      if (observed != expected) begin
         errorCount++;
         $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, " score"}, score, 0);
      checkOutput({tag, " shotsLeft"}, shotsLeft, 10);
      checkOutput({tag, " targetX"}, targetX, 40);
      checkOutput({tag, " targetY"}, targetY, 64);
      checkOutput({tag, " increasePoint"}, increasePoint, 0);
      checkOutput({tag, " holeSel"}, holeSel, 0);
      checkOutput({tag, " gameOver"}, gameOver, 0);
   endtask

   initial begin
      resetN = 1'b0;
      {startGame, shotFired, col4Hole, col3Hole, col2Hole, col1Hole} = 6'b0;
      ballsMoving = 1'b0;
      correctTarget = 1'b0;
      step(2);
      checkResetOutputs("reset");
      resetN = 1'b1;
      step(1);

      $display("[TB] basic shot with no pocketing");
      applyStimulus(P_START);
      checkOutput("start score", score, 0);
      checkOutput("start shotsLeft", shotsLeft, 10);
      applyStimulus(P_SHOT);
      checkOutput("shot1 shotsLeft", shotsLeft, 9);
      step(6);
      checkOutput("shot1 targetX", targetX, 40);
      checkOutput("shot1 targetY", targetY, 64);

      $display("[TB] single correct pocketing");
      applyStimulus(P_SHOT);
      applyStimulus(P_COL2);
      checkOutput("col2 increasePoint", increasePoint, 1);
      checkOutput("col2 holeSel", holeSel, 4'b0010);
      step(1);
      checkOutput("col2 check increasePoint", increasePoint, 0);
      checkOutput("col2 check holeSel", holeSel, 0);
      correctTarget = 1'b1;
      step(1);
      correctTarget = 1'b0;
      checkOutput("col2 score", score, 1);
      step(5);
      rr = cyc % 6;
      checkOutput("col2 target held in END_SHOT", targetX, 40);
      step(1);
      t1 = (rr == 0) ? 1 : rr;
      checkOutput("col2 new targetX", targetX, expX[t1]);
      checkOutput("col2 new targetY", targetY, expY[t1]);

      $display("[TB] simultaneous col1 and col3");
      applyStimulus(P_SHOT);
      applyStimulus(P_COL1 | P_COL3);
      checkOutput("dual first increasePoint", increasePoint, 1);
      checkOutput("dual first holeSel", holeSel, 4'b0001);
      step(1);
      correctTarget = 1'b1;
      checkOutput("dual check increasePoint", increasePoint, 0);
      step(1);
      correctTarget = 1'b0;
      checkOutput("dual score after first", score, 2);
      checkOutput("dual rolling increasePoint", increasePoint, 0);
      step(1);
      checkOutput("dual second increasePoint", increasePoint, 1);
      checkOutput("dual second holeSel", holeSel, 4'b0100);
      step(2);
      checkOutput("dual wrong pocket score", score, 2);
      step(5);
      rr = cyc % 6;
      checkOutput("dual target held in END_SHOT", targetX, expX[t1]);
      step(1);
      t2 = (rr == t1) ? (t1 + 1) % 6 : rr;
      checkOutput("dual new targetX", targetX, expX[t2]);
      checkOutput("dual new targetY", targetY, expY[t2]);

      $display("[TB] settle timing, ignored pulses");
      applyStimulus(P_COL4);
      ipSeen = 0;
      ballsMoving = 1'b1;
      applyStimulus(P_SHOT);
      checkOutput("moving shotsLeft", shotsLeft, 6);
      step(3);
      ballsMoving = 1'b0;
      step(4);
      shotFired = 1'b1;
      step(1);
      checkOutput("shot ignored in ROLLING", shotsLeft, 6);
      step(1);
      checkOutput("shot ignored in END_SHOT", shotsLeft, 6);
      step(1);
      shotFired = 1'b0;
      checkOutput("shot accepted in AIM", shotsLeft, 5);
      checkOutput("aim hole ignored", ipSeen, 0);
      step(6);

      $display("[TB] score saturation");
      applyStimulus(P_SHOT);
      checkOutput("sat shotsLeft", shotsLeft, 4);
      col1Hole = 1'b1;
      correctTarget = 1'b1;
      step(3 * 252);
      checkOutput("sat score 254", score, 254);
      step(3);
      checkOutput("sat score 255", score, 255);
      step(3 * 7);
      checkOutput("sat score held", score, 255);
      col1Hole = 1'b0;
      correctTarget = 1'b0;
      step(20);

      $display("[TB] game over");
      for (int i = 0; i < 3; i++) begin
         applyStimulus(P_SHOT);
         step(8);
      end
      checkOutput("last shot pending shotsLeft", shotsLeft, 1);
      applyStimulus(P_SHOT);
      step(5);
      checkOutput("gameOver in END_SHOT", gameOver, 0);
      checkOutput("final shotsLeft", shotsLeft, 0);
      step(1);
      checkOutput("gameOver set", gameOver, 1);
      applyStimulus(P_SHOT);
      step(1);
      checkOutput("shot ignored in GAME_OVER", shotsLeft, 0);
      checkOutput("gameOver held", gameOver, 1);
      applyStimulus(P_START);
      checkOutput("restart score", score, 0);
      checkOutput("restart shotsLeft", shotsLeft, 10);
      checkOutput("restart targetX", targetX, 40);
      checkOutput("restart targetY", targetY, 64);
      checkOutput("restart gameOver", gameOver, 0);

      $display("[TB] reset during CHECK");
      applyStimulus(P_SHOT);
      applyStimulus(P_COL4);
      checkOutput("col4 holeSel", holeSel, 4'b1000);
      col4Hole = 1'b1;
      correctTarget = 1'b1;
      step(1);
      col4Hole = 1'b0;
      step(1);
      correctTarget = 1'b0;
      checkOutput("col4 score", score, 1);
      step(1);
      checkOutput("col4 reissue increasePoint", increasePoint, 1);
      checkOutput("col4 reissue holeSel", holeSel, 4'b1000);
      col4Hole = 1'b1;
      step(1);
      col4Hole = 1'b0;
      correctTarget = 1'b1;
      #2;
      resetN = 1'b0;
      #1;
      checkResetOutputs("midreset");
      correctTarget = 1'b0;
      step(2);
      resetN = 1'b1;
      ipSeen = 0;
      step(10);
      checkOutput("no issue after reset", ipSeen, 0);
      checkOutput("post reset score", score, 0);
      applyStimulus(P_SHOT);
      step(1);
      checkOutput("shot ignored in IDLE", shotsLeft, 10);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
